// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared sizing constants, the priority-index type and the
//               lowest-set-bit helper for the interrupt/call sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int NIRQ  = 4;
    localparam int PC_W  = 10;
    localparam int IDX_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    localparam logic [PC_W-1:0] VEC_BASE = 10'h3F0;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } idx_t;

    // Index 0 is the highest priority, so the lowest set bit wins.  The loop
    // scans downward so that the last match, which is kept, is the lowest
    // set bit.
    function automatic idx_t lowest_idx(input logic [NIRQ-1:0] vec);
        idx_t r;
        r = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_prio_enc
// Description : Fixed-priority encoder, where the lowest set index wins.
//   i_vec   in  NIRQ   request vector
//   o_idx   out IDX_W  index of the lowest set bit, or 0 when none is set
//   o_valid out 1      at least one bit of i_vec is set
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl_prio_enc
    import irq_pkg::*;
(
    input  logic [NIRQ-1:0]  i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    idx_t w_res;

    always_comb begin
        w_res   = lowest_idx(i_vec);
        o_idx   = w_res.idx;
        o_valid = w_res.valid;
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt/call sequencer for the single-cycle CPU. It drives
//               the return-address stack and the PC vector mux, latches
//               edge-triggered IRQs, applies the mask and the global enable,
//               tracks nested in-service lines and traps stack faults.
//   clk, reset           clock; reset is synchronous and active-high
//   irq_in               IRQ lines; a rising edge requests service
//   mask_we/mask_wdata   mask register write (1 = line enabled)
//   ei_i/di_i            set/clear the global enable (di wins)
//   call_i/ret_i/reti_i  decoder strobes (reti > ret > call)
//   stk_ovf/stk_unf      stack fault flags
//   push/pop/interrupt   stack controls (interrupt = return unincremented)
//   take_irq/vector      PC mux select and vector address
//   in_service/fault     registered status
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    input  logic            ei_i,
    input  logic            di_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic            reti_i,
    input  logic            stk_ovf,
    input  logic            stk_unf,
    output logic            push,
    output logic            pop,
    output logic            interrupt,
    output logic            take_irq,
    output logic [PC_W-1:0] vector,
    output logic [NIRQ-1:0] in_service,
    output logic            fault
);

    logic [NIRQ-1:0]  prev_irq_q,   prev_irq_d;
    logic [NIRQ-1:0]  pending_q,    pending_d;
    logic [NIRQ-1:0]  in_service_q, in_service_d;
    logic [NIRQ-1:0]  mask_q,       mask_d;
    logic             gie_q,        gie_d;
    logic             fault_q,      fault_d;

    logic [NIRQ-1:0]  w_rank_ok;
    logic [NIRQ-1:0]  w_elig;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_valid;
    logic [IDX_W-1:0] w_isv_idx;
    logic             w_isv_valid;
    logic             w_reti;
    logic             w_ret;
    logic             w_call;
    logic             w_take;

    irq_ctrl_prio_enc u_isv_enc (
        .i_vec   (in_service_q),
        .o_idx   (w_isv_idx),
        .o_valid (w_isv_valid)
    );

    // A line may only preempt when it strictly outranks the most urgent
    // line already being serviced.
    for (genvar i = 0; i < NIRQ; i++) begin : g_rank
        assign w_rank_ok[i] = ~w_isv_valid | (IDX_W'(i) < w_isv_idx);
    end

    assign w_elig = pending_q & mask_q & w_rank_ok & {NIRQ{gie_q & ~fault_q}};

    irq_ctrl_prio_enc u_elig_enc (
        .i_vec   (w_elig),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    always_comb begin
        // Decoder strobes are resolved so that at most one takes effect.
        w_reti = reti_i;
        w_ret  = ret_i & ~reti_i;
        w_call = call_i & ~ret_i & ~reti_i;
        w_take = w_sel_valid & ~call_i & ~ret_i & ~reti_i;

        push      = ~reset & (w_take | w_call);
        pop       = ~reset & (w_ret | w_reti);
        interrupt = ~reset & (w_take | w_reti);
        take_irq  = ~reset & w_take;
        vector    = VEC_BASE + PC_W'(w_sel_idx);

        prev_irq_d = irq_in;

        // Clear the taken line first, then OR in new edges, so that a fresh
        // edge arriving on the same line in the take cycle is not lost.
        pending_d = pending_q;
        if (w_take) begin
            pending_d[w_sel_idx] = 1'b0;
        end
        pending_d = pending_d | (irq_in & ~prev_irq_q);

        in_service_d = in_service_q;
        if (w_take) begin
            in_service_d[w_sel_idx] = 1'b1;
        end
        if (w_reti && w_isv_valid) begin
            in_service_d[w_isv_idx] = 1'b0;
        end

        mask_d = mask_we ? mask_wdata : mask_q;

        gie_d = gie_q;
        if (di_i) begin
            gie_d = 1'b0;
        end else if (ei_i) begin
            gie_d = 1'b1;
        end

        fault_d = fault_q | stk_ovf | stk_unf | (w_reti & ~w_isv_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_irq_q   <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '0;
            gie_q        <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            prev_irq_q   <= prev_irq_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            gie_q        <= gie_d;
            fault_q      <= fault_d;
        end
    end

    assign in_service = in_service_q;
    assign fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Scoreboard bench for irq_ctrl. Every cycle that carries a
//               stack/PC event gets its expected event queued. A monitor
//               compares those events with what the DUT presents and flags
//               any event that was not expected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       ei_i, di_i;
    logic       call_i, ret_i, reti_i;
    logic       stk_ovf, stk_unf;
    logic       push, pop, interrupt, take_irq;
    logic [9:0] vector;
    logic [3:0] in_service;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       take;
        logic       push;
        logic       pop;
        logic       intr;
        logic [9:0] vec;
    } ev_t;

    ev_t exp_q[$];

    irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ei_i       (ei_i),
        .di_i       (di_i),
        .call_i     (call_i),
        .ret_i      (ret_i),
        .reti_i     (reti_i),
        .stk_ovf    (stk_ovf),
        .stk_unf    (stk_unf),
        .push       (push),
        .pop        (pop),
        .interrupt  (interrupt),
        .take_irq   (take_irq),
        .vector     (vector),
        .in_service (in_service),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the DUT presents an event whenever push, pop or take_irq is set.
    always @(negedge clk) begin
        if (take_irq || push || pop) begin
            ev_t e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event t=%0t got take=%b push=%b pop=%b intr=%b vec=%h, required none",
                         $time, take_irq, push, pop, interrupt, vector);
            end else begin
                e = exp_q.pop_front();
                if (take_irq !== e.take || push !== e.push || pop !== e.pop ||
                    interrupt !== e.intr || (e.take && vector !== e.vec)) begin
                    n_fail++;
                    $display("FAIL event t=%0t got take=%b push=%b pop=%b intr=%b vec=%h, required take=%b push=%b pop=%b intr=%b vec=%h",
                             $time, take_irq, push, pop, interrupt, vector,
                             e.take, e.push, e.pop, e.intr, e.vec);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic t, input logic p, input logic o,
                             input logic i, input logic [9:0] v);
        ev_t e;
        e.take = t; e.push = p; e.pop = o; e.intr = i; e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; irq_in = 4'hF; mask_we = 1'b0; mask_wdata = 4'h0;
        ei_i = 1'b0; di_i = 1'b0; call_i = 1'b1; ret_i = 1'b0; reti_i = 1'b0;
        stk_ovf = 1'b0; stk_unf = 1'b0;

        // T1: reset gates every output, even with CALL and IRQs present
        #2;
        chk("rst_outs_pre", {7'd0, push, pop, take_irq}, 10'd0);
        step(); step();
        chk("rst_outs", {7'd0, push, pop, take_irq}, 10'd0);
        irq_in = 4'h0; call_i = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("rst_in_service", {6'd0, in_service}, 10'd0);
        chk("rst_fault", {9'd0, fault}, 10'd0);

        // T2: single IRQ on line 2
        mask_we = 1'b1; mask_wdata = 4'hF; ei_i = 1'b1;
        step();
        mask_we = 1'b0; ei_i = 1'b0;
        irq_in = 4'b0100;
        step();
        expect_ev(1, 1, 0, 1, 10'h3F2);
        step();
        chk("t2_isv", {6'd0, in_service}, 10'h004);
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0);
        step();
        reti_i = 1'b0;
        chk("t2_isv_clr", {6'd0, in_service}, 10'h000);

        // T3: nesting -- line 3 cannot preempt line 2, line 0 can
        irq_in = 4'b0000; step();
        irq_in = 4'b0100; step();
        expect_ev(1, 1, 0, 1, 10'h3F2); step();
        irq_in = 4'b1100; step();
        step(); step();
        chk("t3_isv_blocked", {6'd0, in_service}, 10'h004);
        irq_in = 4'b1101; step();
        expect_ev(1, 1, 0, 1, 10'h3F0); step();
        chk("t3_isv_nested", {6'd0, in_service}, 10'h005);
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0); step();
        reti_i = 1'b0;
        chk("t3_isv_reti1", {6'd0, in_service}, 10'h004);
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0); step();
        reti_i = 1'b0;
        chk("t3_isv_reti2", {6'd0, in_service}, 10'h000);
        // Line 3 stayed pending and becomes eligible once nothing is in service
        expect_ev(1, 1, 0, 1, 10'h3F3); step();
        chk("t3_isv_irq3", {6'd0, in_service}, 10'h008);
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0); step();
        reti_i = 1'b0;

        // T4: deferral behind two CALL cycles, then a decoder conflict
        irq_in = 4'b0000; step();
        irq_in = 4'b0010; call_i = 1'b1;
        expect_ev(0, 1, 0, 0, 10'h0); step();
        expect_ev(0, 1, 0, 0, 10'h0); step();
        call_i = 1'b0;
        expect_ev(1, 1, 0, 1, 10'h3F1); step();
        chk("t4_isv", {6'd0, in_service}, 10'h002);
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0); step();
        reti_i = 1'b0;
        call_i = 1'b1; ret_i = 1'b1;
        expect_ev(0, 0, 1, 0, 10'h0); step();
        call_i = 1'b0; ret_i = 1'b0;

        // T5: mask and global enable
        irq_in = 4'b0000; mask_we = 1'b1; mask_wdata = 4'h0; step();
        mask_we = 1'b0;
        irq_in = 4'b1000; step();
        step();
        mask_we = 1'b1; mask_wdata = 4'h8; step();
        mask_we = 1'b0;
        expect_ev(1, 1, 0, 1, 10'h3F3); step();
        chk("t5_isv", {6'd0, in_service}, 10'h008);
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0); step();
        reti_i = 1'b0;
        di_i = 1'b1; step();
        di_i = 1'b0;
        irq_in = 4'b0000; step();
        irq_in = 4'b1000; step();
        step(); step();
        ei_i = 1'b1; di_i = 1'b1; step();
        ei_i = 1'b0; di_i = 1'b0; step();
        chk("t5_di_wins_isv", {6'd0, in_service}, 10'h000);
        ei_i = 1'b1; step();
        ei_i = 1'b0;
        expect_ev(1, 1, 0, 1, 10'h3F3); step();
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0); step();
        reti_i = 1'b0;

        // T6: a bad RETI sets the sticky fault, which blocks all takes
        chk("t6_fault_pre", {9'd0, fault}, 10'd0);
        reti_i = 1'b1; expect_ev(0, 0, 1, 1, 10'h0); step();
        reti_i = 1'b0;
        chk("t6_fault_set", {9'd0, fault}, 10'd1);
        irq_in = 4'b0000; step();
        irq_in = 4'b1000; step();
        step(); step();
        call_i = 1'b1; expect_ev(0, 1, 0, 0, 10'h0); step();
        call_i = 1'b0;
        chk("t6_fault_sticky", {9'd0, fault}, 10'd1);
        irq_in = 4'b0000; reset = 1'b1; step();
        reset = 1'b0; step();
        chk("t6_fault_reset", {9'd0, fault}, 10'd0);
        stk_unf = 1'b1; step();
        stk_unf = 1'b0;
        chk("t6_fault_unf", {9'd0, fault}, 10'd1);

        step(); step();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d leftover events, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
